// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared encodings for the sdram request arbiter: FSM state codes, the
//   latched operation code, default bus widths and the round-robin pointer
//   increment helper.
//   No ports; imported by the interface, the top and the picker.
package sdram_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef logic arb_op_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int ARB_DEF_AW = 24;
    localparam int ARB_DEF_DW = 16;

    // Next round-robin start position after port idx was served, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if
//   Bundles every bus signal around the arbiter: the NREQ requester ports
//   (s_*), the status outputs (grant, busy) and the single sdram port (m_*).
//   Modports:
//     slave  - the arbiter itself: serves requesters, drives the sdram port
//     master - the surroundings: requesters plus the sdram controller
//   Signals:
//     s_read_req/s_write_req [NREQ]    level requests, held until s_ack
//     s_address [NREQ*AW], s_data_in [NREQ*DW]   port i at [i*W +: W]
//     s_ack [NREQ], s_data_out [DW], s_err       completion to the winner
//     grant [NREQ], busy                         current owner / activity
//     m_address, m_data_in, m_read_req, m_write_req   to sdram
//     m_read_ack, m_write_ack, m_data_out             from sdram
interface sdram_req_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = ARB_DEF_AW,
    parameter int DW   = ARB_DEF_DW
);
    logic [NREQ-1:0]    s_read_req;
    logic [NREQ-1:0]    s_write_req;
    logic [NREQ*AW-1:0] s_address;
    logic [NREQ*DW-1:0] s_data_in;
    logic [NREQ-1:0]    s_ack;
    logic [DW-1:0]      s_data_out;
    logic               s_err;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [AW-1:0]      m_address;
    logic [DW-1:0]      m_data_in;
    logic               m_read_req;
    logic               m_write_req;
    logic               m_read_ack;
    logic               m_write_ack;
    logic [DW-1:0]      m_data_out;

    modport slave (
        input  s_read_req, s_write_req, s_address, s_data_in,
               m_read_ack, m_write_ack, m_data_out,
        output s_ack, s_data_out, s_err, grant, busy,
               m_address, m_data_in, m_read_req, m_write_req
    );

    modport master (
        output s_read_req, s_write_req, s_address, s_data_in,
               m_read_ack, m_write_ack, m_data_out,
        input  s_ack, s_data_out, s_err, grant, busy,
               m_address, m_data_in, m_read_req, m_write_req
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches pending starting at ptr,
//   then ptr+1, ... modulo NREQ, and returns the first pending port.
//   Ports:
//     pending     in  NREQ  per-port request (read or write)
//     ptr         in  PW    search start position, 0..NREQ-1
//     win         out NREQ  one-hot winner, 0 when nothing pending
//     any_pending out 1     at least one port pending
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            any_pending
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        win         = '0;
        any_pending = |pending;
        found       = 1'b0;
        idx         = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = PW'((int'(ptr) + off) % NREQ);
            if (!found && pending[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
//   Round-robin arbiter sharing the single-word sdram req/ack port between
//   NREQ requesters. Latches the winner's address, data and op, drives the
//   sdram port, and returns ack (and read data) to the winner only.
//   Ports:
//     sys_clk  in  clock, rising edge
//     sys_rst  in  asynchronous active-high reset
//     bus      sdram_req_arbiter_if.slave - requester ports, grant/busy and
//              the sdram port (see the interface file)
//   Parameters: NREQ (2..8), AW, DW, TIMEOUT (0 disables forced release).
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AW      = ARB_DEF_AW,
    parameter int DW      = ARB_DEF_DW,
    parameter int TIMEOUT = 4095
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    sdram_req_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    arb_state_t      state_q,  state_d;
    logic [PW-1:0]   ptr_q,    ptr_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [NREQ-1:0] grant_q,  grant_d;
    arb_op_t         op_q,     op_d;
    logic [AW-1:0]   addr_q,   addr_d;
    logic [DW-1:0]   wdata_q,  wdata_d;
    logic            rd_req_q, rd_req_d;
    logic            wr_req_q, wr_req_d;
    logic [NREQ-1:0] ack_q,    ack_d;
    logic            err_q,    err_d;
    logic [DW-1:0]   rdata_q,  rdata_d;

    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] win;
    logic            any_pending;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_next;
    logic [CW-1:0]   cnt_inc;
    logic            ack_hit;
    logic            timeout_hit;

    assign pending = bus.s_read_req | bus.s_write_req;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .pending     (pending),
        .ptr         (ptr_q),
        .win         (win),
        .any_pending (any_pending)
    );

    // Index of the current owner; grant_q is one-hot while BUSY/RELEASE.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign ptr_next    = PW'(rr_next(int'(win_idx), NREQ));
    assign cnt_inc     = cnt_q + CW'(1);
    // Only the ack matching the latched op completes; the other is ignored.
    assign ack_hit     = (op_q == OP_WR) ? bus.m_write_ack : bus.m_read_ack;
    // cnt_inc hits TIMEOUT on the TIMEOUT-th BUSY cycle, so the sdram request
    // stays up for exactly TIMEOUT cycles. A real ack in that cycle wins.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIMIT);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_req_d = rd_req_q;
        wr_req_d = wr_req_q;
        ack_d    = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (any_pending) begin
                    // Write takes precedence when a port raises both requests.
                    for (int i = 0; i < NREQ; i++) begin
                        if (win[i]) begin
                            addr_d  = bus.s_address[i*AW +: AW];
                            wdata_d = bus.s_data_in[i*DW +: DW];
                            op_d    = bus.s_write_req[i] ? OP_WR : OP_RD;
                        end
                    end
                    grant_d  = win;
                    rd_req_d = ~op_d;
                    wr_req_d = op_d;
                    state_d  = ST_BUSY;
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_inc;
                if (ack_hit) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    ack_d    = grant_q;
                    if (op_q == OP_RD) begin
                        rdata_d = bus.m_data_out;
                    end
                    ptr_d   = ptr_next;
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    ack_d    = grant_q;
                    err_d    = 1'b1;
                    ptr_d    = ptr_next;
                    state_d  = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // Staying here at least one cycle lets the winner drop its
                // request before IDLE samples again.
                if (!bus.m_read_ack && !bus.m_write_ack) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
            end
        endcase
    end

    // Async reset also drops the sdram request immediately; the controller
    // must tolerate an abandoned transfer.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.s_ack       = ack_q;
    assign bus.s_err       = err_q;
    assign bus.s_data_out  = rdata_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.m_address   = addr_q;
    assign bus.m_data_in   = wdata_q;
    assign bus.m_read_req  = rd_req_q;
    assign bus.m_write_req = wr_req_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter
//   Self-checking bench for sdram_req_arbiter: directed scenarios followed by
//   randomized request traffic, all checked against a round-robin model held
//   here (pointer + pending arrays + last read data).
module tb_sdram_req_arbiter;

    localparam int NREQ    = 3;
    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int TIMEOUT = 16;

    logic sys_clk;
    logic sys_rst;

    sdram_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    sdram_req_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Requester-side state and reference model
    logic [NREQ-1:0] tb_rd;
    logic [NREQ-1:0] tb_wr;
    logic [AW-1:0]   tb_addr  [NREQ];
    logic [DW-1:0]   tb_wdata [NREQ];
    int              model_ptr;
    logic [DW-1:0]   model_rdata;
    int              vectors;
    int              miscompares;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < NREQ; i++) begin
            bus.s_address[i*AW +: AW] = tb_addr[i];
            bus.s_data_in[i*DW +: DW] = tb_wdata[i];
        end
        bus.s_read_req  = tb_rd;
        bus.s_write_req = tb_wr;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int p);
        logic [NREQ-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // First pending port at or after the model pointer, -1 if none.
    function automatic int model_pick();
        for (int k = 0; k < NREQ; k++) begin
            int p;
            p = (model_ptr + k) % NREQ;
            if (tb_rd[p] || tb_wr[p]) return p;
        end
        return -1;
    endfunction

    // One complete transfer from IDLE with port w expected to win.
    // ack_delay: BUSY cycle in which the sdram acks (0 = never, forces timeout).
    // spurious: raise the non-matching read ack during a write.
    // hold: extra cycles the sdram keeps its ack high (RELEASE must wait).
    task automatic run_transfer(input int w, input int ack_delay, input logic [DW-1:0] rdata,
                                input bit spurious, input int hold);
        bit is_wr;
        is_wr = tb_wr[w];
        @(posedge sys_clk); #1;
        check_output("grant", 64'(bus.grant), 64'(onehot(w)));
        check_output("busy", 64'(bus.busy), 64'(1));
        check_output("m_write_req", 64'(bus.m_write_req), 64'(is_wr));
        check_output("m_read_req", 64'(bus.m_read_req), 64'(!is_wr));
        check_output("m_address", 64'(bus.m_address), 64'(tb_addr[w]));
        if (is_wr) check_output("m_data_in", 64'(bus.m_data_in), 64'(tb_wdata[w]));
        if (ack_delay == 0) begin
            for (int c = 2; c <= TIMEOUT; c++) begin
                @(posedge sys_clk); #1;
            end
            check_output("req_held_until_timeout", 64'(bus.m_read_req | bus.m_write_req), 64'(1));
            @(posedge sys_clk); #1;
            check_output("timeout_s_ack", 64'(bus.s_ack), 64'(onehot(w)));
            check_output("timeout_s_err", 64'(bus.s_err), 64'(1));
            check_output("timeout_req_drop", 64'(bus.m_read_req | bus.m_write_req), 64'(0));
            check_output("timeout_s_data_out", 64'(bus.s_data_out), 64'(model_rdata));
            tb_rd[w] = 1'b0;
            tb_wr[w] = 1'b0;
            apply_stimulus();
        end else begin
            for (int c = 1; c <= ack_delay; c++) begin
                if (c > 1) begin
                    @(posedge sys_clk); #1;
                end
                if (spurious && c == 2) begin
                    bus.m_read_ack = 1'b1;
                    bus.m_data_out = DW'($urandom);
                end
                if (spurious && c == 3) begin
                    check_output("spurious_keeps_write", 64'(bus.m_write_req), 64'(1));
                    check_output("spurious_no_ack", 64'(bus.s_ack), 64'(0));
                    bus.m_read_ack = 1'b0;
                end
            end
            if (is_wr) bus.m_write_ack = 1'b1;
            else       bus.m_read_ack  = 1'b1;
            bus.m_data_out = is_wr ? DW'($urandom) : rdata;
            if (!is_wr) model_rdata = rdata;
            @(posedge sys_clk); #1;
            check_output("s_ack", 64'(bus.s_ack), 64'(onehot(w)));
            check_output("s_err", 64'(bus.s_err), 64'(0));
            check_output("req_drop", 64'(bus.m_read_req | bus.m_write_req), 64'(0));
            check_output("s_data_out", 64'(bus.s_data_out), 64'(model_rdata));
            tb_rd[w] = 1'b0;
            tb_wr[w] = 1'b0;
            apply_stimulus();
            for (int h = 0; h < hold; h++) begin
                @(posedge sys_clk); #1;
                check_output("release_waits_grant", 64'(bus.grant), 64'(onehot(w)));
                check_output("release_waits_ack", 64'(bus.s_ack), 64'(0));
            end
            bus.m_read_ack  = 1'b0;
            bus.m_write_ack = 1'b0;
        end
        model_ptr = (w + 1) % NREQ;
        @(posedge sys_clk); #1;
        check_output("idle_grant", 64'(bus.grant), 64'(0));
        check_output("idle_busy", 64'(bus.busy), 64'(0));
        check_output("ack_pulse_end", 64'(bus.s_ack), 64'(0));
        check_output("err_pulse_end", 64'(bus.s_err), 64'(0));
    endtask

    initial begin
        int w;
        int dly;
        int op;
        bit spur;

        vectors     = 0;
        miscompares = 0;
        model_ptr   = 0;
        model_rdata = '0;
        tb_rd       = '0;
        tb_wr       = '0;
        for (int i = 0; i < NREQ; i++) begin
            tb_addr[i]  = '0;
            tb_wdata[i] = '0;
        end
        bus.m_read_ack  = 1'b0;
        bus.m_write_ack = 1'b0;
        bus.m_data_out  = '0;
        apply_stimulus();
        sys_rst = 1'b1;

        // Reset state
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        check_output("rst_grant", 64'(bus.grant), 64'(0));
        check_output("rst_busy", 64'(bus.busy), 64'(0));
        check_output("rst_s_ack", 64'(bus.s_ack), 64'(0));
        check_output("rst_s_err", 64'(bus.s_err), 64'(0));
        check_output("rst_m_req", 64'({bus.m_read_req, bus.m_write_req}), 64'(0));
        check_output("rst_m_address", 64'(bus.m_address), 64'(0));
        check_output("rst_s_data_out", 64'(bus.s_data_out), 64'(0));
        sys_rst = 1'b0;

        // All three ports write-pending from reset; port 0 re-requests at once
        $display("[TB] round-robin order 0,1,2,0");
        for (int i = 0; i < NREQ; i++) begin
            tb_wr[i]    = 1'b1;
            tb_addr[i]  = AW'(24'h000100 * (i + 1));
            tb_wdata[i] = DW'(16'hA000 + i);
        end
        apply_stimulus();
        run_transfer(0, 2, '0, 1'b0, 0);
        tb_wr[0]    = 1'b1;
        tb_addr[0]  = 24'h000400;
        tb_wdata[0] = 16'h5A5A;
        apply_stimulus();
        run_transfer(1, 3, '0, 1'b0, 0);
        run_transfer(2, 1, '0, 1'b0, 0);
        run_transfer(0, 4, '0, 1'b0, 0);

        // Port 1 read, sdram answers in the 7th BUSY cycle with 0xBEEF
        $display("[TB] port 1 read 0xBEEF");
        tb_rd[1]   = 1'b1;
        tb_addr[1] = 24'h000010;
        apply_stimulus();
        run_transfer(1, 7, 16'hBEEF, 1'b0, 0);

        // Port 2 read never acked -> timeout, then port 0 is served
        $display("[TB] timeout then next port");
        tb_rd[2]    = 1'b1;
        tb_addr[2]  = 24'h0ABCDE;
        tb_wr[0]    = 1'b1;
        tb_addr[0]  = 24'h000777;
        tb_wdata[0] = 16'h1234;
        apply_stimulus();
        run_transfer(2, 0, '0, 1'b0, 0);
        run_transfer(0, 3, '0, 1'b0, 0);

        // Port 1 raises read and write together; spurious read ack; held ack
        $display("[TB] read+write together");
        tb_rd[1]    = 1'b1;
        tb_wr[1]    = 1'b1;
        tb_addr[1]  = 24'h123456;
        tb_wdata[1] = 16'hC0DE;
        apply_stimulus();
        run_transfer(1, 5, '0, 1'b1, 1);

        // Reset during BUSY of port 2 while port 0 also waits
        $display("[TB] reset during busy");
        tb_wr[2]    = 1'b1;
        tb_addr[2]  = 24'h00F00D;
        tb_wdata[2] = 16'h7777;
        tb_wr[0]    = 1'b1;
        tb_addr[0]  = 24'h00BEAD;
        tb_wdata[0] = 16'h8888;
        apply_stimulus();
        @(posedge sys_clk); #1;
        check_output("pre_reset_grant", 64'(bus.grant), 64'(onehot(2)));
        @(posedge sys_clk); #1;
        #3 sys_rst = 1'b1;
        #1;
        check_output("async_rst_m_req", 64'({bus.m_read_req, bus.m_write_req}), 64'(0));
        check_output("async_rst_grant", 64'(bus.grant), 64'(0));
        check_output("async_rst_busy", 64'(bus.busy), 64'(0));
        check_output("async_rst_s_data_out", 64'(bus.s_data_out), 64'(0));
        @(posedge sys_clk); #1;
        sys_rst     = 1'b0;
        model_ptr   = 0;
        model_rdata = '0;
        run_transfer(0, 4, '0, 1'b0, 0);
        run_transfer(2, 2, '0, 1'b0, 0);

        // Randomized traffic against the round-robin model
        $display("[TB] random traffic");
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < NREQ; p++) begin
                if (!(tb_rd[p] || tb_wr[p]) && $urandom_range(0, 1) == 1) begin
                    op          = int'($urandom_range(0, 2));
                    tb_rd[p]    = (op != 1);
                    tb_wr[p]    = (op != 0);
                    tb_addr[p]  = AW'($urandom);
                    tb_wdata[p] = DW'($urandom);
                end
            end
            if (tb_rd == '0 && tb_wr == '0) begin
                op          = int'($urandom_range(0, NREQ - 1));
                tb_rd[op]   = 1'b1;
                tb_addr[op] = AW'($urandom);
            end
            apply_stimulus();
            w    = model_pick();
            dly  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            spur = tb_wr[w] && (dly >= 3) && ($urandom_range(0, 1) == 1);
            run_transfer(w, dly, DW'($urandom), spur, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
